// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
//
// Control block for a minutes/seconds stopwatch. It turns three push buttons
// into start/stop, lap and clear actions. It generates the count tick and the
// counter clear for an external minutes/seconds counter. It also multiplexes
// four seven-segment digits, showing either the live counter value or a
// frozen lap snapshot.
//
// Parameters
//   PRESCALE   CLK cycles per count tick (>= 2)
//   SCAN_DIV   CLK cycles each digit stays lit (>= 2)
//
// Ports
//   CLK, RST                    clock, asynchronous active-high reset
//   BTN_SS, BTN_LAP, BTN_CLR    raw button levels (asynchronous)
//   M_TENS, M_ONES, S_TENS,
//   S_ONES                      live digits from the minutes/seconds counter
//   CNT_CLK                     one-cycle count pulse to the counter
//   CNT_RST                     counter clear (high during reset, then one
//                               cycle per accepted clear)
//   RUNNING, LAP_ACTIVE         status
//   DIG_SEL                     one-hot digit enable (bit 0 = seconds ones)
//   SEG                         segments a..g on bits 0..6, active-high
//   DP                          separator dot, lit with the minutes-ones digit
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int PRESCALE = 1000,
  parameter int SCAN_DIV = 250
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_SS,
  input  logic       BTN_LAP,
  input  logic       BTN_CLR,
  input  logic [3:0] M_TENS,
  input  logic [3:0] M_ONES,
  input  logic [2:0] S_TENS,
  input  logic [3:0] S_ONES,
  output logic       CNT_CLK,
  output logic       CNT_RST,
  output logic       RUNNING,
  output logic       LAP_ACTIVE,
  output logic [3:0] DIG_SEL,
  output logic [6:0] SEG,
  output logic       DP
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    CLEARED = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2
  } stateT;

  stateT state;
  stateT nextState;

  logic [2:0] btnSync1;
  logic [2:0] btnSync2;
  logic [2:0] btnHist;
  logic [2:0] btnEvt;
  logic       ssEvt;
  logic       lapEvt;
  logic       clrEvt;
  logic       clrAccepted;
  logic       keepRunning;

  logic [PW-1:0] prescaleCnt;
  logic [SW-1:0] scanCnt;
  logic [1:0]    digIdx;

  logic       lapActive;
  logic [3:0] lapMTens;
  logic [3:0] lapMOnes;
  logic [2:0] lapSTens;
  logic [3:0] lapSOnes;

  logic [3:0] shownMTens;
  logic [3:0] shownMOnes;
  logic [3:0] shownSTens;
  logic [3:0] shownSOnes;
  logic [3:0] digVal;
  logic [3:0] selNext;
  logic [6:0] segNext;
  logic       dpNext;

  // Seven-segment pattern for one BCD digit; codes above 9 stay dark.
  function automatic logic [6:0] sevenSeg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Button front end. Each button goes through two flops to settle
  // metastability. A history flop remembers the previous settled level, so a
  // rising edge becomes a single-cycle event. The event itself is registered,
  // which keeps the FSM input a clean flop output. As a result, a press seen
  // at edge N reaches the FSM during the cycle after edge N+2.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      btnSync1 <= '0;
      btnSync2 <= '0;
      btnHist  <= '0;
      btnEvt   <= '0;
    end else begin
      btnSync1 <= {BTN_CLR, BTN_LAP, BTN_SS};
      btnSync2 <= btnSync1;
      btnHist  <= btnSync2;
      btnEvt   <= btnSync2 & ~btnHist;
    end
  end

  assign ssEvt  = btnEvt[0];
  assign lapEvt = btnEvt[1];
  assign clrEvt = btnEvt[2];

  // State register for the run/pause/clear machine.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= CLEARED;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic. Clear wins over start/stop whenever it is allowed at
  // all (cleared or paused). While running, clear is ignored completely, so
  // a simultaneous start/stop is the only thing acted on. keepRunning marks
  // cycles that are running now and stay running. The prescaler only counts
  // in those cycles, which stops CNT_CLK from firing into a pause.
  always_comb begin
    nextState   = state;
    clrAccepted = 1'b0;
    case (state)
      CLEARED: begin
        if (clrEvt) begin
          clrAccepted = 1'b1;
        end else if (ssEvt) begin
          nextState = RUN;
        end
      end
      RUN: begin
        if (ssEvt) begin
          nextState = PAUSED;
        end
      end
      PAUSED: begin
        if (clrEvt) begin
          clrAccepted = 1'b1;
          nextState   = CLEARED;
        end else if (ssEvt) begin
          nextState = RUN;
        end
      end
      default: begin
        nextState = CLEARED;
      end
    endcase
    keepRunning = (state == RUN) && (nextState == RUN);
  end

  assign RUNNING = (state == RUN);

  // Counter clear. It stays high while reset is held, then drops on the
  // first edge after release. Afterwards it pulses once for each clear the
  // FSM accepted on the previous edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CNT_RST <= 1'b1;
    end else begin
      CNT_RST <= clrAccepted;
    end
  end

  // Tick prescaler. It counts 0..PRESCALE-1 while running and holds its
  // phase across a pause, so resuming continues the partial tick. Going to
  // CLEARED zeroes it, so a fresh start waits a full PRESCALE cycles before
  // the first tick. The count pulse is registered on the wrap.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prescaleCnt <= '0;
      CNT_CLK     <= 1'b0;
    end else begin
      CNT_CLK <= 1'b0;
      if (nextState == CLEARED) begin
        prescaleCnt <= '0;
      end else if (keepRunning) begin
        if (prescaleCnt == PRE_LAST) begin
          prescaleCnt <= '0;
          CNT_CLK     <= 1'b1;
        end else begin
          prescaleCnt <= prescaleCnt + PW'(1);
        end
      end
    end
  end

  // Lap capture. The first lap press while running freezes all four live
  // digits. The next lap press, running or paused, releases them. Clearing
  // always drops an active lap. In CLEARED the lap flag is already low, and
  // the snapshot needs RUN, so lap presses there do nothing.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lapActive <= 1'b0;
      lapMTens  <= '0;
      lapMOnes  <= '0;
      lapSTens  <= '0;
      lapSOnes  <= '0;
    end else if (nextState == CLEARED) begin
      lapActive <= 1'b0;
    end else if (lapEvt) begin
      if (lapActive) begin
        lapActive <= 1'b0;
      end else if (state == RUN) begin
        lapActive <= 1'b1;
        lapMTens  <= M_TENS;
        lapMOnes  <= M_ONES;
        lapSTens  <= S_TENS;
        lapSOnes  <= S_ONES;
      end
    end
  end

  assign LAP_ACTIVE = lapActive;

  // Display scan timing. This runs freely, independent of the stopwatch
  // state: scanCnt sets how long each digit stays lit, and digIdx steps
  // through the four digits.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      scanCnt <= '0;
      digIdx  <= 2'd0;
    end else if (scanCnt == SCAN_LAST) begin
      scanCnt <= '0;
      digIdx  <= digIdx + 2'd1;
    end else begin
      scanCnt <= scanCnt + SW'(1);
    end
  end

  // Digit selection. Choose the lap or live source, pick the digit for the
  // current index, and decode it. A leading zero in the tens-of-minutes
  // position is blanked, but its enable still fires so the scan timing stays
  // uniform.
  always_comb begin
    shownMTens = lapActive ? lapMTens : M_TENS;
    shownMOnes = lapActive ? lapMOnes : M_ONES;
    shownSTens = {1'b0, (lapActive ? lapSTens : S_TENS)};
    shownSOnes = lapActive ? lapSOnes : S_ONES;
    digVal     = shownSOnes;
    selNext    = 4'b0001;
    dpNext     = 1'b0;
    case (digIdx)
      2'd0: begin
        selNext = 4'b0001;
        digVal  = shownSOnes;
      end
      2'd1: begin
        selNext = 4'b0010;
        digVal  = shownSTens;
      end
      2'd2: begin
        selNext = 4'b0100;
        digVal  = shownMOnes;
        dpNext  = 1'b1;
      end
      default: begin
        selNext = 4'b1000;
        digVal  = shownMTens;
      end
    endcase
    segNext = sevenSeg(digVal);
    if ((digIdx == 2'd3) && (digVal == 4'd0)) begin
      segNext = 7'h00;
    end
  end

  // Display output register. Enable, segments and dot all load on the same
  // edge, so the panel never shows one digit's pattern under another digit's
  // enable.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DIG_SEL <= 4'b0001;
      SEG     <= 7'h00;
      DP      <= 1'b0;
    end else begin
      DIG_SEL <= selNext;
      SEG     <= segNext;
      DP      <= dpNext;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Self-checking bench for stopwatch_ctrl with PRESCALE=4 and SCAN_DIV=2.
// Display behaviour is checked through a table of digit vectors feeding a
// scoreboard queue. Run/pause/clear, lap and reset behaviour are checked by
// hand-written cycle sequences.
// ---------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  logic       clk;
  logic       rst;
  logic       btnSs;
  logic       btnLap;
  logic       btnClr;
  logic [3:0] mTens;
  logic [3:0] mOnes;
  logic [2:0] sTens;
  logic [3:0] sOnes;
  logic       cntClk;
  logic       cntRst;
  logic       running;
  logic       lapActive;
  logic [3:0] digSel;
  logic [6:0] seg;
  logic       dp;

  int checks   = 0;
  int failures = 0;
  int edgeCount;

  typedef struct packed {
    logic [3:0] digSel;
    logic [6:0] seg;
    logic       dp;
  } dispT;

  typedef struct {
    logic [3:0]      mT;
    logic [3:0]      mO;
    logic [2:0]      sT;
    logic [3:0]      sO;
    logic [3:0][6:0] segs;
  } vecT;

  dispT dispQ[$];
  vecT  vecs[5];

  stopwatch_ctrl #(
    .PRESCALE(4),
    .SCAN_DIV(2)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .BTN_SS(btnSs),
    .BTN_LAP(btnLap),
    .BTN_CLR(btnClr),
    .M_TENS(mTens),
    .M_ONES(mOnes),
    .S_TENS(sTens),
    .S_ONES(sOnes),
    .CNT_CLK(cntClk),
    .CNT_RST(cntRst),
    .RUNNING(running),
    .LAP_ACTIVE(lapActive),
    .DIG_SEL(digSel),
    .SEG(seg),
    .DP(dp)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges seen since reset was released; the expected scan position comes
  // from this.
  always @(posedge clk or posedge rst) begin
    if (rst) edgeCount <= 0;
    else     edgeCount <= edgeCount + 1;
  end

  // Hard stop in case something upstream wedges the bench.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkSig(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic stepCheck(input string tag, input logic expClk, input logic expRst, input logic expRun);
    step();
    checkSig({tag, "_cntClk"}, {7'd0, cntClk}, {7'd0, expClk});
    checkSig({tag, "_cntRst"}, {7'd0, cntRst}, {7'd0, expRst});
    checkSig({tag, "_running"}, {7'd0, running}, {7'd0, expRun});
  endtask

  // Drive live digits. Then queue the display word expected after the next
  // edge: the scan position then is floor(edgeCount/2) mod 4.
  task automatic applyStimulus(input logic [3:0] mT, input logic [3:0] mO,
                               input logic [2:0] sT, input logic [3:0] sO,
                               input logic [3:0][6:0] expSegs);
    int   idx;
    dispT e;
    mTens = mT;
    mOnes = mO;
    sTens = sT;
    sOnes = sO;
    idx = (edgeCount / 2) % 4;
    e.digSel = 4'b0001 << idx;
    e.seg    = expSegs[idx];
    e.dp     = (idx == 2);
    dispQ.push_back(e);
  endtask

  task automatic checkOutput(input string name);
    dispT e;
    checks++;
    if (dispQ.size() == 0) begin
      failures++;
      $display("[TB] FAIL %s: scoreboard empty", name);
    end else begin
      e = dispQ.pop_front();
      if ({digSel, seg, dp} !== e) begin
        failures++;
        $display("[TB] FAIL %s: got sel=%b seg=%h dp=%b expected sel=%b seg=%h dp=%b",
                 name, digSel, seg, dp, e.digSel, e.seg, e.dp);
      end
    end
  endtask

  task automatic runRotation(input string name, input logic [3:0] mT, input logic [3:0] mO,
                             input logic [2:0] sT, input logic [3:0] sO,
                             input logic [3:0][6:0] expSegs);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(mT, mO, sT, sO, expSegs);
      step();
      checkOutput(name);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkSig({tag, "_cntRst"}, {7'd0, cntRst}, 8'd1);
    checkSig({tag, "_cntClk"}, {7'd0, cntClk}, 8'd0);
    checkSig({tag, "_running"}, {7'd0, running}, 8'd0);
    checkSig({tag, "_lapActive"}, {7'd0, lapActive}, 8'd0);
    checkSig({tag, "_digSel"}, {4'd0, digSel}, 8'h01);
    checkSig({tag, "_seg"}, {1'b0, seg}, 8'h00);
    checkSig({tag, "_dp"}, {7'd0, dp}, 8'd0);
  endtask

  initial begin
    bit found;
    logic [3:0][6:0] seg0523;
    logic [3:0][6:0] seg1748;

    vecs[0] = '{4'd0,  4'd5,  3'd2, 4'd3,  {7'h00, 7'h6D, 7'h5B, 7'h4F}};
    vecs[1] = '{4'd1,  4'd9,  3'd5, 4'd9,  {7'h06, 7'h6F, 7'h6D, 7'h6F}};
    vecs[2] = '{4'd9,  4'd8,  3'd7, 4'd6,  {7'h6F, 7'h7F, 7'h07, 7'h7D}};
    vecs[3] = '{4'd10, 4'd4,  3'd0, 4'd10, {7'h00, 7'h66, 7'h3F, 7'h00}};
    vecs[4] = '{4'd15, 4'd10, 3'd1, 4'd15, {7'h00, 7'h00, 7'h06, 7'h00}};
    seg0523 = {7'h00, 7'h6D, 7'h5B, 7'h4F};
    seg1748 = {7'h06, 7'h07, 7'h66, 7'h7F};

    rst = 1'b1;
    btnSs = 1'b0; btnLap = 1'b0; btnClr = 1'b0;
    mTens = 4'd0; mOnes = 4'd0; sTens = 3'd0; sOnes = 4'd0;

    $display("[TB] reset state");
    step();
    step();
    checkResetOutputs("reset");
    rst = 1'b0;
    step();
    checkSig("releaseCntRst", {7'd0, cntRst}, 8'd0);
    checkSig("releaseRunning", {7'd0, running}, 8'd0);

    $display("[TB] display scan table");
    foreach (vecs[v]) begin
      runRotation($sformatf("scanVec%0d", v), vecs[v].mT, vecs[v].mO, vecs[v].sT, vecs[v].sO, vecs[v].segs);
    end

    $display("[TB] start from cleared");
    btnSs = 1'b1;
    for (int c = 1; c <= 3; c++) stepCheck("ssSync", 1'b0, 1'b0, 1'b0);
    stepCheck("runEntry", 1'b0, 1'b0, 1'b1);
    btnSs = 1'b0;
    for (int c = 1; c <= 7; c++) stepCheck("runTicks", logic'(c == 4), 1'b0, 1'b1);

    $display("[TB] pause with prescaler at 2, then resume");
    btnSs = 1'b1;
    stepCheck("pauseA", 1'b1, 1'b0, 1'b1);
    stepCheck("pauseB", 1'b0, 1'b0, 1'b1);
    stepCheck("pauseC", 1'b0, 1'b0, 1'b1);
    stepCheck("pauseEntry", 1'b0, 1'b0, 1'b0);
    btnSs = 1'b0;
    for (int c = 1; c <= 5; c++) stepCheck("pausedHold", 1'b0, 1'b0, 1'b0);
    btnSs = 1'b1;
    for (int c = 1; c <= 3; c++) stepCheck("resumeSync", 1'b0, 1'b0, 1'b0);
    stepCheck("resumeEntry", 1'b0, 1'b0, 1'b1);
    btnSs = 1'b0;
    stepCheck("resumeTick1", 1'b0, 1'b0, 1'b1);
    stepCheck("resumeTick2", 1'b1, 1'b0, 1'b1);

    $display("[TB] clear while running is ignored");
    btnClr = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      stepCheck("clrInRun", logic'(c == 4), 1'b0, 1'b1);
      if (c == 4) btnClr = 1'b0;
    end

    $display("[TB] pause, then start/stop and clear together");
    btnSs = 1'b1;
    for (int c = 1; c <= 3; c++) stepCheck("pause2", logic'(c == 2), 1'b0, 1'b1);
    stepCheck("pause2Entry", 1'b0, 1'b0, 1'b0);
    btnSs = 1'b0;
    for (int c = 1; c <= 3; c++) stepCheck("pause2Hold", 1'b0, 1'b0, 1'b0);
    btnSs = 1'b1;
    btnClr = 1'b1;
    for (int c = 1; c <= 3; c++) stepCheck("ssClrSync", 1'b0, 1'b0, 1'b0);
    stepCheck("ssClrPulse", 1'b0, 1'b1, 1'b0);
    btnSs = 1'b0;
    btnClr = 1'b0;
    for (int c = 1; c <= 3; c++) stepCheck("ssClrAfter", 1'b0, 1'b0, 1'b0);

    $display("[TB] lap capture and release");
    mTens = 4'd0; mOnes = 4'd5; sTens = 3'd2; sOnes = 4'd3;
    btnSs = 1'b1;
    for (int c = 1; c <= 3; c++) stepCheck("restartSync", 1'b0, 1'b0, 1'b0);
    stepCheck("restartEntry", 1'b0, 1'b0, 1'b1);
    btnSs = 1'b0;
    for (int c = 1; c <= 4; c++) stepCheck("restartTicks", logic'(c == 4), 1'b0, 1'b1);
    btnLap = 1'b1;
    for (int c = 1; c <= 3; c++) step();
    checkSig("lapBeforeSet", {7'd0, lapActive}, 8'd0);
    step();
    checkSig("lapSet", {7'd0, lapActive}, 8'd1);
    btnLap = 1'b0;
    runRotation("lapFrozen", 4'd1, 4'd7, 3'd4, 4'd8, seg0523);
    checkSig("lapStillSet", {7'd0, lapActive}, 8'd1);
    btnLap = 1'b1;
    for (int c = 1; c <= 4; c++) step();
    checkSig("lapCleared", {7'd0, lapActive}, 8'd0);
    btnLap = 1'b0;
    runRotation("lapReleased", 4'd1, 4'd7, 3'd4, 4'd8, seg1748);

    $display("[TB] reset in the middle of a run with lap active");
    btnLap = 1'b1;
    for (int c = 1; c <= 4; c++) step();
    checkSig("lapSetAgain", {7'd0, lapActive}, 8'd1);
    btnLap = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      step();
      if (cntClk === 1'b1) found = 1'b1;
    end
    checkSig("waitCntClk", {7'd0, found}, 8'd1);
    #2;
    rst = 1'b1;
    #1;
    checkResetOutputs("midReset");
    step();
    step();
    checkResetOutputs("midResetHeld");
    rst = 1'b0;
    stepCheck("postRelease", 1'b0, 1'b0, 1'b0);
    checkSig("postReleaseLap", {7'd0, lapActive}, 8'd0);
    for (int c = 1; c <= 8; c++) stepCheck("postReleaseIdle", 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
